mem_rd_arbiter: RTL and testbench

MEM_RD_ARBITER -- requirements
Module: mem_rd_arbiter

---
 rtl/mem_rd_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_rd_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_arbiter.sv
// Two-port (I-cache / D-cache) burst read arbiter onto one shared memory read channel.
// Define ARB_RR_EN for round-robin arbitration; otherwise the D-cache wins every conflict.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_rsp_valid,
  output logic [31:0]       ic_rsp_data,
  output logic              ic_rsp_last,
  input  logic              ic_rsp_ready,
  // D-cache
  input  logic              dc_req_valid,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  output logic              dc_rsp_valid,
  output logic [31:0]       dc_rsp_data,
  output logic              dc_rsp_last,
  input  logic              dc_rsp_ready,
  // Memory
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_last,
  output logic              mem_rsp_ready
);

  typedef enum logic [2:0] {
    StIdle = 3'b001,
    StReq  = 3'b010,
    StData = 3'b100
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_own_ic;
  logic              r_own_dc;
  logic [ADDR_W-1:0] r_addr;
  logic              w_grant;
  logic              w_grant_dc;
  logic              w_burst_done;

  assign w_grant      = ic_req_valid | dc_req_valid;
  assign w_burst_done = mem_rsp_valid & mem_rsp_ready & mem_rsp_last;

`ifdef ARB_RR_EN
  logic r_last_dc;

  // Reset value lets the I-cache win the first conflict after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_dc <= 1'b1;
    end else if ((r_state == StIdle) && w_grant) begin
      r_last_dc <= w_grant_dc;
    end
  end

  assign w_grant_dc = dc_req_valid & (~ic_req_valid | ~r_last_dc);
`else
  assign w_grant_dc = dc_req_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (w_grant)       w_state_nxt = StReq;
      StReq:   if (mem_req_ready) w_state_nxt = StData;
      StData:  if (w_burst_done)  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Owner and address are frozen from grant until the burst ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_own_ic <= 1'b0;
      r_own_dc <= 1'b0;
      r_addr   <= '0;
    end else if ((r_state == StIdle) && w_grant) begin
      r_own_ic <= ~w_grant_dc;
      r_own_dc <= w_grant_dc;
      r_addr   <= w_grant_dc ? dc_req_addr : ic_req_addr;
    end else if ((r_state == StData) && w_burst_done) begin
      r_own_ic <= 1'b0;
      r_own_dc <= 1'b0;
    end
  end

  assign mem_req_addr = r_addr;
  assign ic_rsp_data  = mem_rsp_data;
  assign dc_rsp_data  = mem_rsp_data;

  always_comb begin
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    ic_req_ready  = 1'b0;
    dc_req_ready  = 1'b0;
    ic_rsp_valid  = 1'b0;
    dc_rsp_valid  = 1'b0;
    ic_rsp_last   = 1'b0;
    dc_rsp_last   = 1'b0;
    unique case (r_state)
      StReq: begin
        mem_req_valid = 1'b1;
        ic_req_ready  = r_own_ic & mem_req_ready;
        dc_req_ready  = r_own_dc & mem_req_ready;
      end
      StData: begin
        ic_rsp_valid  = r_own_ic & mem_rsp_valid;
        dc_rsp_valid  = r_own_dc & mem_rsp_valid;
        ic_rsp_last   = r_own_ic & mem_rsp_last;
        dc_rsp_last   = r_own_dc & mem_rsp_last;
        mem_rsp_ready = (r_own_ic & ic_rsp_ready) | (r_own_dc & dc_rsp_ready);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed self-checking bench for mem_rd_arbiter; expectations follow ARB_RR_EN when defined.
module tb_mem_rd_arbiter;

  logic        clk;
  logic        rst;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_req_ready;
  logic        ic_rsp_valid;
  logic [31:0] ic_rsp_data;
  logic        ic_rsp_last;
  logic        ic_rsp_ready;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic        dc_req_ready;
  logic        dc_rsp_valid;
  logic [31:0] dc_rsp_data;
  logic        dc_rsp_last;
  logic        dc_rsp_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_last;
  logic        mem_rsp_ready;

  int checks = 0;
  int errors = 0;

`ifdef ARB_RR_EN
  localparam bit FirstDc = 1'b0;
`else
  localparam bit FirstDc = 1'b1;
`endif
  localparam logic [31:0] FirstAddr  = FirstDc ? 32'h0000_2000 : 32'h0000_3040;
  localparam logic [31:0] SecondAddr = FirstDc ? 32'h0000_3040 : 32'h0000_2000;

  mem_rd_arbiter #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ic_req_valid (ic_req_valid),
    .ic_req_addr  (ic_req_addr),
    .ic_req_ready (ic_req_ready),
    .ic_rsp_valid (ic_rsp_valid),
    .ic_rsp_data  (ic_rsp_data),
    .ic_rsp_last  (ic_rsp_last),
    .ic_rsp_ready (ic_rsp_ready),
    .dc_req_valid (dc_req_valid),
    .dc_req_addr  (dc_req_addr),
    .dc_req_ready (dc_req_ready),
    .dc_rsp_valid (dc_rsp_valid),
    .dc_rsp_data  (dc_rsp_data),
    .dc_rsp_last  (dc_rsp_last),
    .dc_rsp_ready (dc_rsp_ready),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .mem_rsp_last (mem_rsp_last),
    .mem_rsp_ready(mem_rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ic_req_valid  = 1'b0;
    ic_req_addr   = '0;
    ic_rsp_ready  = 1'b0;
    dc_req_valid  = 1'b0;
    dc_req_addr   = '0;
    dc_rsp_ready  = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_last  = 1'b0;
  endtask

  initial begin
    // Reset with every input asserted: all handshake outputs must stay low.
    rst           = 1'b1;
    clear_inputs();
    ic_req_valid  = 1'b1;
    dc_req_valid  = 1'b1;
    ic_rsp_ready  = 1'b1;
    dc_rsp_ready  = 1'b1;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_last  = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
    chkw("rst_mem_req_addr", mem_req_addr, 32'h0);
    chk1("rst_ic_req_ready", ic_req_ready, 1'b0);
    chk1("rst_dc_req_ready", dc_req_ready, 1'b0);
    chk1("rst_mem_rsp_ready", mem_rsp_ready, 1'b0);
    chk1("rst_ic_rsp_valid", ic_rsp_valid, 1'b0);
    chk1("rst_dc_rsp_valid", dc_rsp_valid, 1'b0);
    chk1("rst_ic_rsp_last", ic_rsp_last, 1'b0);
    chk1("rst_dc_rsp_last", dc_rsp_last, 1'b0);

    // IC-only burst, 2-cycle request wait, 8 beats, stall on beat 4.
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_1020;
    #1 chk1("t1_idle_req_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    #1;
    chk1("t1_req_valid", mem_req_valid, 1'b1);
    chkw("t1_req_addr", mem_req_addr, 32'h0000_1020);
    chk1("t1_wait1_ready", ic_req_ready, 1'b0);
    @(negedge clk);
    #1 chk1("t1_wait2_ready", ic_req_ready, 1'b0);
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk1("t1_ic_req_ready", ic_req_ready, 1'b1);
    chk1("t1_dc_req_ready", dc_req_ready, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ic_req_valid  = 1'b0;
      mem_req_ready = 1'b0;
      if (i == 3) begin
        ic_rsp_ready  = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h14;
        mem_rsp_last  = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk1("t1_stall_mem_rsp_ready", mem_rsp_ready, 1'b0);
          chk1("t1_stall_ic_rsp_valid", ic_rsp_valid, 1'b1);
          chkw("t1_stall_ic_rsp_data", ic_rsp_data, 32'h14);
          @(negedge clk);
        end
      end
      ic_rsp_ready  = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'(32'h11 + i);
      mem_rsp_last  = (i == 7);
      #1;
      chk1("t1_ic_rsp_valid", ic_rsp_valid, 1'b1);
      chkw("t1_ic_rsp_data", ic_rsp_data, 32'(32'h11 + i));
      chk1("t1_ic_rsp_last", ic_rsp_last, (i == 7));
      chk1("t1_mem_rsp_ready", mem_rsp_ready, 1'b1);
      chk1("t1_dc_rsp_valid", dc_rsp_valid, 1'b0);
      chkw("t1_addr_hold", mem_req_addr, 32'h0000_1020);
    end
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    #1;
    chk1("t1_idle_mem_rsp_ready", mem_rsp_ready, 1'b0);
    chk1("t1_idle_ic_rsp_valid", ic_rsp_valid, 1'b0);
    chk1("t1_idle_mem_req_valid", mem_req_valid, 1'b0);

    // Simultaneous requests straight after reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_3040;
    dc_req_valid = 1'b1;
    dc_req_addr  = 32'h0000_2000;
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk1("t2_req_valid", mem_req_valid, 1'b1);
    chkw("t2_first_addr", mem_req_addr, FirstAddr);
    chk1("t2_first_ic_ready", ic_req_ready, ~FirstDc);
    chk1("t2_first_dc_ready", dc_req_ready, FirstDc);
    @(negedge clk);
    ic_req_valid  = FirstDc;
    dc_req_valid  = ~FirstDc;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_last  = 1'b1;
    mem_rsp_data  = 32'hAA;
    ic_rsp_ready  = 1'b1;
    dc_rsp_ready  = 1'b1;
    #1;
    chk1("t2_first_ic_rsp_valid", ic_rsp_valid, ~FirstDc);
    chk1("t2_first_dc_rsp_valid", dc_rsp_valid, FirstDc);
    chkw("t2_ic_rsp_data", ic_rsp_data, 32'hAA);
    chkw("t2_dc_rsp_data", dc_rsp_data, 32'hAA);
    chk1("t2_mem_rsp_ready", mem_rsp_ready, 1'b1);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    #1 chk1("t2_gap_idle", mem_req_valid, 1'b0);
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk1("t2_second_req_valid", mem_req_valid, 1'b1);
    chkw("t2_second_addr", mem_req_addr, SecondAddr);
    chk1("t2_second_ic_ready", ic_req_ready, FirstDc);
    chk1("t2_second_dc_ready", dc_req_ready, ~FirstDc);
    @(negedge clk);
    ic_req_valid  = 1'b0;
    dc_req_valid  = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_last  = 1'b1;
    mem_rsp_data  = 32'hBB;
    #1;
    chk1("t2_second_ic_rsp_last", ic_rsp_last, FirstDc);
    chk1("t2_second_dc_rsp_last", dc_rsp_last, ~FirstDc);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    #1 chk1("t2_end_idle", mem_req_valid, 1'b0);

    // DC request arriving during an IC data phase must wait.
    ic_req_valid = 1'b1;
    ic_req_addr  = 32'h0000_4000;
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk1("t3_ic_req_ready", ic_req_ready, 1'b1);
    chkw("t3_ic_addr", mem_req_addr, 32'h0000_4000);
    @(negedge clk);
    ic_req_valid  = 1'b0;
    dc_req_valid  = 1'b1;
    dc_req_addr   = 32'h0000_5000;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h41;
    mem_rsp_last  = 1'b0;
    #1;
    chk1("t3_dc_wait_beat1", dc_req_ready, 1'b0);
    chk1("t3_ic_rsp_valid", ic_rsp_valid, 1'b1);
    chk1("t3_dc_rsp_valid", dc_rsp_valid, 1'b0);
    chkw("t3_addr_hold", mem_req_addr, 32'h0000_4000);
    @(negedge clk);
    mem_rsp_data = 32'h42;
    mem_rsp_last = 1'b1;
    #1;
    chk1("t3_dc_wait_beat2", dc_req_ready, 1'b0);
    chk1("t3_ic_rsp_last", ic_rsp_last, 1'b1);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_last  = 1'b0;
    #1;
    chk1("t3_gap_req_valid", mem_req_valid, 1'b0);
    chk1("t3_gap_dc_ready", dc_req_ready, 1'b0);
    @(negedge clk);
    #1;
    chk1("t3_dc_req_valid", mem_req_valid, 1'b1);
    chkw("t3_dc_addr", mem_req_addr, 32'h0000_5000);
    chk1("t3_dc_req_ready", dc_req_ready, 1'b1);
    chk1("t3_ic_req_ready", ic_req_ready, 1'b0);

    // Reset on beat 5 of the DC burst, then a fresh IC request.
    @(negedge clk);
    dc_req_valid  = 1'b0;
    mem_req_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b > 1) @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'(32'h50 + b);
      mem_rsp_last  = 1'b0;
      if (b == 5) rst = 1'b1;
      #1;
      chk1("t4_dc_rsp_valid", dc_rsp_valid, 1'b1);
      chkw("t4_dc_rsp_data", dc_rsp_data, 32'(32'h50 + b));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("t4_rst_mem_req_valid", mem_req_valid, 1'b0);
    chkw("t4_rst_mem_req_addr", mem_req_addr, 32'h0);
    chk1("t4_rst_mem_rsp_ready", mem_rsp_ready, 1'b0);
    chk1("t4_rst_dc_rsp_valid", dc_rsp_valid, 1'b0);
    chk1("t4_rst_ic_rsp_valid", ic_rsp_valid, 1'b0);
    chk1("t4_rst_dc_req_ready", dc_req_ready, 1'b0);
    mem_rsp_valid = 1'b0;
    ic_req_valid  = 1'b1;
    ic_req_addr   = 32'h0000_6000;
    @(negedge clk);
    mem_req_ready = 1'b1;
    #1;
    chk1("t4_ic_req_valid", mem_req_valid, 1'b1);
    chkw("t4_ic_addr", mem_req_addr, 32'h0000_6000);
    chk1("t4_ic_req_ready", ic_req_ready, 1'b1);
    @(negedge clk);
    ic_req_valid  = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h61;
    mem_rsp_last  = 1'b1;
    ic_rsp_ready  = 1'b1;
    #1;
    chk1("t4_ic_rsp_valid", ic_rsp_valid, 1'b1);
    chk1("t4_ic_rsp_last", ic_rsp_last, 1'b1);
    @(negedge clk);
    clear_inputs();
    #1 chk1("t4_end_mem_rsp_ready", mem_rsp_ready, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
